cmem_pair_sched: RTL and testbench

Sequencer that applies one single-qubit gate to the whole complex state memory. It walks every amplitude pair (i0, i1 = i0 | 1<<k) for a target qubit k. For each pair it reads both words through the memory's addressed single-word port, hands them to an external 2x2 butterfly unit over a valid/ready handshake, and writes the two results back in place. It sits between the top-level control and the state memory plus butterfly datapath, and drives the memory's w_en, addr and D_in inputs. It holds new_state low at all times.

---
 rtl/cmem_pair_sched_if.sv | 32 +++
 rtl/cmem_pair_sched.sv | 174 +++++++++++++++++
 tb/tb_cmem_pair_sched.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cmem_pair_sched_if.sv
// Bus bundle between the pair scheduler, the state memory word port and the butterfly unit.
// master = scheduler side, slave = memory/butterfly side.
interface cmem_pair_sched_if #(
    parameter int N      = 8,
    parameter int DATA_W = 32
);
    localparam int AW = $clog2(N);

    logic [AW-1:0]       mem_addr;
    logic                mem_w_en;
    logic                mem_new_state;
    logic [2*DATA_W-1:0] mem_wdata;
    logic [2*DATA_W-1:0] mem_rdata;

    logic                bf_valid;
    logic                bf_ready;
    logic [2*DATA_W-1:0] bf_a;
    logic [2*DATA_W-1:0] bf_b;
    logic                bf_out_valid;
    logic [2*DATA_W-1:0] bf_y0;
    logic [2*DATA_W-1:0] bf_y1;

    modport master (
        output mem_addr, mem_w_en, mem_new_state, mem_wdata, bf_valid, bf_a, bf_b,
        input  mem_rdata, bf_ready, bf_out_valid, bf_y0, bf_y1
    );

    modport slave (
        input  mem_addr, mem_w_en, mem_new_state, mem_wdata, bf_valid, bf_a, bf_b,
        output mem_rdata, bf_ready, bf_out_valid, bf_y0, bf_y1
    );
endinterface

// File: rtl/cmem_pair_sched.sv
// Walks every amplitude pair (i0, i0|1<<k) of the state memory, runs each pair through the
// external butterfly and writes both results back in place.
module cmem_pair_sched #(
    parameter int N      = 8,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [$clog2(N)-1:0] target,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    cmem_pair_sched_if.master    bus
);
    localparam int LOG_N = $clog2(N);
    localparam int PW    = (LOG_N > 1) ? LOG_N - 1 : 1;
    localparam int WW    = 2 * DATA_W;
    localparam logic [PW-1:0]  P_LAST  = PW'(N / 2 - 1);
    localparam logic [LOG_N:0] LOG_N_V = (LOG_N + 1)'(LOG_N);

    typedef enum logic [2:0] {
        S_IDLE, S_RD0, S_RD1, S_ISSUE, S_WAIT, S_WR0, S_WR1
    } state_t;

    state_t            r_state, w_state_next;
    logic [LOG_N-1:0]  r_k, w_k_next;
    logic [PW-1:0]     r_p, w_p_next;
    logic [LOG_N-1:0]  r_addr, w_addr_next;
    logic              r_w_en, w_w_en_next;
    logic [WW-1:0]     r_wdata, w_wdata_next;
    logic [WW-1:0]     r_a, w_a_next;
    logic [WW-1:0]     r_b, w_b_next;
    logic [WW-1:0]     r_y1, w_y1_next;
    logic              r_valid, w_valid_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;

    // Addresses are registered, so they are derived from the next p/k for the state being entered.
    logic [LOG_N-1:0]  w_pe;
    logic [LOG_N-1:0]  w_i0;
    logic [LOG_N-1:0]  w_i1;

    assign w_pe = LOG_N'(w_p_next);

    generate
        for (genvar gi = 0; gi < LOG_N; gi++) begin : g_ins
            if (gi == 0) begin : g_lsb
                assign w_i0[0] = (w_k_next == '0) ? 1'b0 : w_pe[0];
            end else begin : g_hi
                assign w_i0[gi] = (LOG_N'(gi) < w_k_next)  ? w_pe[gi]  :
                                  (LOG_N'(gi) == w_k_next) ? 1'b0      : w_pe[gi-1];
            end
        end
    endgenerate

    assign w_i1 = w_i0 | (LOG_N'(1) << w_k_next);

    always_comb begin
        w_state_next = r_state;
        w_k_next     = r_k;
        w_p_next     = r_p;
        w_a_next     = r_a;
        w_b_next     = r_b;
        w_y1_next    = r_y1;
        w_wdata_next = r_wdata;
        w_w_en_next  = 1'b0;
        w_valid_next = 1'b0;
        w_done_next  = 1'b0;
        w_err_next   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if ({1'b0, target} < LOG_N_V) begin
                        w_k_next     = target;
                        w_p_next     = '0;
                        w_state_next = S_RD0;
                    end else begin
                        w_err_next = 1'b1;
                    end
                end
            end
            S_RD0: begin
                w_a_next     = bus.mem_rdata;
                w_state_next = S_RD1;
            end
            S_RD1: begin
                w_b_next     = bus.mem_rdata;
                w_valid_next = 1'b1;
                w_state_next = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.bf_ready) begin
                    w_state_next = S_WAIT;
                end else begin
                    w_valid_next = 1'b1;
                end
            end
            S_WAIT: begin
                if (bus.bf_out_valid) begin
                    w_y1_next    = bus.bf_y1;
                    w_wdata_next = bus.bf_y0;
                    w_w_en_next  = 1'b1;
                    w_state_next = S_WR0;
                end
            end
            S_WR0: begin
                w_wdata_next = r_y1;
                w_w_en_next  = 1'b1;
                w_state_next = S_WR1;
            end
            S_WR1: begin
                if (r_p == P_LAST) begin
                    w_done_next  = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_p_next     = r_p + PW'(1);
                    w_state_next = S_RD0;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_addr_next = r_addr;
        case (w_state_next)
            S_RD0, S_WR0: w_addr_next = w_i0;
            S_RD1, S_WR1: w_addr_next = w_i1;
            default:      w_addr_next = r_addr;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_p     <= '0;
            r_addr  <= '0;
            r_w_en  <= 1'b0;
            r_wdata <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_y1    <= '0;
            r_valid <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_k     <= w_k_next;
            r_p     <= w_p_next;
            r_addr  <= w_addr_next;
            r_w_en  <= w_w_en_next;
            r_wdata <= w_wdata_next;
            r_a     <= w_a_next;
            r_b     <= w_b_next;
            r_y1    <= w_y1_next;
            r_valid <= w_valid_next;
            r_done  <= w_done_next;
            r_err   <= w_err_next;
        end
    end

    assign busy              = (r_state != S_IDLE);
    assign done              = r_done;
    assign err               = r_err;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_w_en      = r_w_en;
    assign bus.mem_new_state = 1'b0;
    assign bus.mem_wdata     = r_wdata;
    assign bus.bf_valid      = r_valid;
    assign bus.bf_a          = r_a;
    assign bus.bf_b          = r_b;
endmodule

// File: tb/tb_cmem_pair_sched.sv
// Directed bench for cmem_pair_sched: behavioural word memory plus a swapping butterfly model
// (y0 = b, y1 = a) with programmable result delay.
module tb_cmem_pair_sched;
    localparam int N  = 8;
    localparam int DW = 32;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] target;
    logic       busy;
    logic       done;
    logic       err;

    cmem_pair_sched_if #(.N(N), .DATA_W(DW)) bus ();

    cmem_pair_sched #(.N(N), .DATA_W(DW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .target (target),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Memory model with combinational read and a write log
    logic [63:0] mem [N];
    logic        preload;
    logic [2:0]  la [$];
    logic [63:0] ld [$];
    int          done_cnt = 0;
    int          err_cnt  = 0;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int j = 0; j < N; j++) mem[j] <= 64'(j);
        end else if (bus.mem_w_en) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
    end

    always @(posedge clk) begin
        if (bus.mem_w_en) begin
            la.push_back(bus.mem_addr);
            ld.push_back(bus.mem_wdata);
        end
        if (done) done_cnt <= done_cnt + 1;
        if (err)  err_cnt  <= err_cnt + 1;
    end

    // Butterfly model: delay 0 returns results in the first WAIT cycle
    int          bf_delay;
    int          bf_cnt;
    logic [63:0] cap_a, cap_b;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.bf_out_valid <= 1'b0;
            bus.bf_y0        <= '0;
            bus.bf_y1        <= '0;
            bf_cnt           <= -1;
        end else begin
            bus.bf_out_valid <= 1'b0;
            if (bus.bf_valid && bus.bf_ready) begin
                if (bf_delay == 0) begin
                    bus.bf_out_valid <= 1'b1;
                    bus.bf_y0        <= bus.bf_b;
                    bus.bf_y1        <= bus.bf_a;
                end else begin
                    cap_a  <= bus.bf_a;
                    cap_b  <= bus.bf_b;
                    bf_cnt <= bf_delay - 1;
                end
            end else if (bf_cnt == 0) begin
                bus.bf_out_valid <= 1'b1;
                bus.bf_y0        <= cap_b;
                bus.bf_y1        <= cap_a;
                bf_cnt           <= -1;
            end else if (bf_cnt > 0) begin
                bf_cnt <= bf_cnt - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_mem(input string tag, input int e[N]);
        for (int i = 0; i < N; i++) chk($sformatf("%s mem[%0d]", tag, i), mem[i], 64'(e[i]));
    endtask

    task automatic check_log(input string tag, input int base, input int ea[N], input int ed[N]);
        chk($sformatf("%s write count", tag), 64'(la.size() - base), 64'(N));
        for (int i = 0; i < N; i++) begin
            if (base + i < la.size()) begin
                chk($sformatf("%s wr%0d addr", tag, i), 64'(la[base+i]), 64'(ea[i]));
                chk($sformatf("%s wr%0d data", tag, i), ld[base+i], 64'(ed[i]));
            end
        end
    endtask

    task automatic wait_done(input int cyc_in, output int cyc_out);
        int c = cyc_in;
        while (done !== 1'b1 && c < 300) begin
            @(negedge clk);
            c++;
        end
        cyc_out = c;
    endtask

    task automatic do_preload();
        preload = 1'b1;
        @(negedge clk);
        preload = 1'b0;
    endtask

    task automatic run_gate(input logic [2:0] t, input int exp_cyc, input string tag);
        int c;
        target = t;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(1, c);
        chk({tag, " latency"}, 64'(c), 64'(exp_cyc));
    endtask

    int exp_a1 [N] = '{0, 2, 1, 3, 4, 6, 5, 7};
    int exp_d1 [N] = '{2, 0, 3, 1, 6, 4, 7, 5};
    int exp_m1 [N] = '{2, 3, 0, 1, 6, 7, 4, 5};
    int exp_a2 [N] = '{0, 4, 1, 5, 2, 6, 3, 7};
    int exp_d2 [N] = '{4, 0, 5, 1, 6, 2, 7, 3};
    int exp_m2 [N] = '{4, 5, 6, 7, 0, 1, 2, 3};
    int exp_m6a[N] = '{2, 3, 0, 1, 4, 5, 6, 7};
    int exp_m6b[N] = '{0, 1, 2, 3, 6, 7, 4, 5};

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int base, d0, e0, c, n;
        clk          = 1'b0;
        rst          = 1'b0;
        start        = 1'b0;
        target       = '0;
        preload      = 1'b0;
        bus.bf_ready = 1'b1;
        bf_delay     = 0;

        repeat (2) @(negedge clk);
        chk("rst busy",      64'(busy), 64'd0);
        chk("rst done",      64'(done), 64'd0);
        chk("rst err",       64'(err), 64'd0);
        chk("rst w_en",      64'(bus.mem_w_en), 64'd0);
        chk("rst bf_valid",  64'(bus.bf_valid), 64'd0);
        chk("rst addr",      64'(bus.mem_addr), 64'd0);
        chk("rst wdata",     bus.mem_wdata, 64'd0);
        chk("rst bf_a",      bus.bf_a, 64'd0);
        chk("rst bf_b",      bus.bf_b, 64'd0);
        chk("rst new_state", 64'(bus.mem_new_state), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Scenario 1: target 1, swap model, 25-cycle latency
        do_preload();
        base = la.size();
        d0   = done_cnt;
        run_gate(3'd1, 25, "t1");
        chk("t1 busy at done", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t1 done pulse width", 64'(done), 64'd0);
        chk("t1 done count", 64'(done_cnt - d0), 64'd1);
        check_log("t1", base, exp_a1, exp_d1);
        check_mem("t1", exp_m1);

        // Scenario 2: target 2
        do_preload();
        base = la.size();
        run_gate(3'd2, 25, "t2");
        @(negedge clk);
        check_log("t2", base, exp_a2, exp_d2);
        check_mem("t2", exp_m2);

        // Scenario 3: out-of-range target
        base   = la.size();
        e0     = err_cnt;
        target = 3'd3;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("t3 err pulse", 64'(err), 64'd1);
        chk("t3 busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("t3 err cleared", 64'(err), 64'd0);
        chk("t3 busy later", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("t3 no writes", 64'(la.size() - base), 64'd0);
        chk("t3 err count", 64'(err_cnt - e0), 64'd1);

        // Scenario 4: stalled ready and delayed results on the first pair
        do_preload();
        base         = la.size();
        d0           = done_cnt;
        bus.bf_ready = 1'b0;
        bf_delay     = 4;
        target       = 3'd1;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (bus.bf_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t4 bf_valid raised", 64'(bus.bf_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("t4 hold%0d valid", i), 64'(bus.bf_valid), 64'd1);
            chk($sformatf("t4 hold%0d bf_a", i), bus.bf_a, 64'd0);
            chk($sformatf("t4 hold%0d bf_b", i), bus.bf_b, 64'd2);
            @(negedge clk);
        end
        bus.bf_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) bf_delay = 0;
            chk($sformatf("t4 wait%0d w_en", i), 64'(bus.mem_w_en), 64'd0);
            chk($sformatf("t4 wait%0d bf_valid", i), 64'(bus.bf_valid), 64'd0);
        end
        @(negedge clk);
        chk("t4 first write", 64'(bus.mem_w_en), 64'd1);
        wait_done(0, c);
        chk("t4 done seen", 64'(done), 64'd1);
        @(negedge clk);
        chk("t4 done count", 64'(done_cnt - d0), 64'd1);
        check_log("t4", base, exp_a1, exp_d1);
        check_mem("t4", exp_m1);

        // Scenario 5: second start and target change while busy are ignored
        do_preload();
        base   = la.size();
        d0     = done_cnt;
        target = 3'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        target = 3'd2;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(9, c);
        chk("t5 latency", 64'(c), 64'd25);
        @(negedge clk);
        chk("t5 done count", 64'(done_cnt - d0), 64'd1);
        check_log("t5", base, exp_a1, exp_d1);
        check_mem("t5", exp_m1);

        // Scenario 6: reset during WAIT of the third pair, then a clean rerun
        do_preload();
        base   = la.size();
        target = 3'd1;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (la.size() - base < 4 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("t6 two pairs written", 64'(la.size() - base), 64'd4);
        bf_delay = 3;
        n = 0;
        while (bus.bf_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("t6 third issue", 64'(bus.bf_valid), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6 busy", 64'(busy), 64'd0);
        chk("t6 done", 64'(done), 64'd0);
        chk("t6 err", 64'(err), 64'd0);
        chk("t6 w_en", 64'(bus.mem_w_en), 64'd0);
        chk("t6 bf_valid", 64'(bus.bf_valid), 64'd0);
        chk("t6 addr", 64'(bus.mem_addr), 64'd0);
        chk("t6 wdata", bus.mem_wdata, 64'd0);
        chk("t6 bf_a", bus.bf_a, 64'd0);
        chk("t6 bf_b", bus.bf_b, 64'd0);
        @(negedge clk);
        chk("t6 writes kept", 64'(la.size() - base), 64'd4);
        check_mem("t6 partial", exp_m6a);
        rst      = 1'b1;
        bf_delay = 0;
        @(negedge clk);
        run_gate(3'd1, 25, "t6 rerun");
        @(negedge clk);
        check_mem("t6 rerun", exp_m6b);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
